// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver: the in-flight prediction
// record, counter saturation limits and the default sizing.
package branch_resolver_pkg;

   localparam int DEFAULT_DEPTH    = 4;
   localparam int DEFAULT_IDX_BITS = 4;

   localparam logic [1:0] CTR_MIN = 2'd0;
   localparam logic [1:0] CTR_MAX = 2'd3;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [1:0]  ctr;
      logic [31:0] target;
   } pred_entry_t;

   // Saturating 2-bit counter step toward the actual outcome.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] result;
      if (taken) begin
         result = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
      end else begin
         result = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
      end
      return result;
   endfunction

   // A target mismatch only matters when both prediction and outcome are taken.
   function automatic logic is_mispredict(input pred_entry_t entry,
                                          input logic        taken,
                                          input logic [31:0] target);
      return (entry.taken != taken) || (entry.taken && taken && (entry.target != target));
   endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// Circular queue of in-flight predictions. Pointers carry one extra wrap bit
// so full and empty are told apart by comparing their MSBs.
module branch_pred_fifo
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  pred_entry_t push_entry,
   output pred_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   pred_entry_t   mem [DEPTH];

   logic pop_ok;
   logic flush_ok;
   logic push_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees a slot in the same cycle, so a full queue still takes a push
   // alongside a pop; a flush discards everything, including that push.
   assign pop_ok   = pop && !empty;
   assign flush_ok = flush && pop_ok;
   assign push_ok  = push && !flush_ok && (!full || pop_ok);

   assign head = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_ok) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_entry;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches in order against EX outcomes and produces the
// registered redirect, predictor update and statistics.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pred_valid,
   input  logic [31:0]         pred_pc,
   input  logic                pred_taken,
   input  logic [1:0]          pred_ctr,
   input  logic [31:0]         pred_target,
   output logic                pred_ready,
   input  logic                res_valid,
   input  logic                res_taken,
   input  logic [31:0]         res_target,
   output logic                mispredict,
   output logic [31:0]         redirect_pc,
   output logic                upd_valid,
   output logic [IDX_BITS-1:0] upd_index,
   output logic [1:0]          upd_ctr,
   output logic [15:0]         branch_count,
   output logic [15:0]         mispredict_count
);

   pred_entry_t push_entry;
   pred_entry_t head;
   logic        full;
   logic        empty;
   logic        do_pop;
   logic        wrong;

   assign push_entry = '{pc: pred_pc, taken: pred_taken, ctr: pred_ctr, target: pred_target};

   assign pred_ready = !full;
   assign do_pop     = res_valid && !empty;
   assign wrong      = do_pop && is_mispredict(head, res_taken, res_target);

   branch_pred_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pred_valid),
      .pop       (res_valid),
      .flush     (wrong),
      .push_entry(push_entry),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   // Result outputs are live only for the cycle after a resolving pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         upd_valid   <= 1'b0;
         mispredict  <= 1'b0;
         upd_index   <= '0;
         upd_ctr     <= '0;
         redirect_pc <= '0;
      end else if (do_pop) begin
         upd_valid   <= 1'b1;
         mispredict  <= wrong;
         upd_index   <= head.pc[IDX_BITS+1:2];
         upd_ctr     <= ctr_update(head.ctr, res_taken);
         redirect_pc <= res_taken ? res_target : head.pc + 32'd4;
      end else begin
         upd_valid   <= 1'b0;
         mispredict  <= 1'b0;
         upd_index   <= '0;
         upd_ctr     <= '0;
         redirect_pc <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (do_pop) begin
         if (branch_count != 16'hFFFF) begin
            branch_count <= branch_count + 16'd1;
         end
         if (wrong && (mispredict_count != 16'hFFFF)) begin
            mispredict_count <= mispredict_count + 16'd1;
         end
      end
   end

endmodule
